// File: rtl/alu_pkg.sv
// alu_pkg: command encodings and flag bundle shared by the ALU pipeline.
// Holds CMD_* codes (3-bit), the flags struct and the subtract decode.
package alu_pkg;

    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_ADD  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_SUB  = 3'd1;
    localparam logic [CMD_W-1:0] CMD_XOR  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_SLT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_AND  = 3'd4;
    localparam logic [CMD_W-1:0] CMD_NAND = 3'd5;
    localparam logic [CMD_W-1:0] CMD_NOR  = 3'd6;
    localparam logic [CMD_W-1:0] CMD_OR   = 3'd7;

    typedef struct packed {
        logic carryout;
        logic zero;
        logic overflow;
    } alu_flags_t;

    // SLT shares the subtractor: it is decided from A - B.
    function automatic logic is_sub(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_SUB) || (cmd == CMD_SLT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU producing result and flags.
// Ports: operandA/operandB/command in; result and flags out.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [CMD_W-1:0] command,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    logic             subtract;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             add_ovf;

    assign subtract = is_sub(command);
    assign b_eff    = subtract ? ~operandB : operandB;

    // One adder serves ADD, SUB and SLT; the +1 of the
    // two's complement rides in as the carry-in.
    assign {cout, sum} = {1'b0, operandA}
                       + {1'b0, b_eff}
                       + {{WIDTH{1'b0}}, subtract};

    assign add_ovf = (operandA[WIDTH-1] == b_eff[WIDTH-1])
                  && (sum[WIDTH-1] != operandA[WIDTH-1]);

    always_comb begin
        result = '0;
        flags  = '0;
        unique case (command)
            CMD_ADD, CMD_SUB: begin
                result         = sum;
                flags.carryout = cout;
                flags.overflow = add_ovf;
            end
            // Signed less-than: sign of A-B corrected by overflow.
            CMD_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            CMD_XOR:  result = operandA ^ operandB;
            CMD_AND:  result = operandA & operandB;
            CMD_NAND: result = ~(operandA & operandB);
            CMD_NOR:  result = ~(operandA | operandB);
            CMD_OR:   result = operandA | operandB;
            default:  result = '0;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: ALU with STAGES registered stages and valid/ready backpressure.
// In: clk, reset, inValid, operandA, operandB, command, outReady.
// Out: inReady, outValid, result, carryout, zero, overflow.
// ALU_STICKY_OVF_EN adds clearSticky (in) and stickyOverflow (out).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [CMD_W-1:0] command,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic             clearSticky,
    output logic             stickyOverflow
`endif
);

    logic [WIDTH-1:0]  core_result;
    alu_flags_t        core_flags;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  res_q [STAGES];
    alu_flags_t        flg_q [STAGES];

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .operandA(operandA),
        .operandB(operandB),
        .command (command),
        .result  (core_result),
        .flags   (core_flags)
    );

    // Stage k may advance when it, or any stage after it, is a
    // bubble, or when the consumer takes the last stage. This is
    // the unrolled form of adv_k = !valid_k || adv_(k+1).
    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = outReady;
            for (int j = k; j < STAGES; j++) begin
                if (!vld[j]) begin
                    adv[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                flg_q[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= inValid;
                if (inValid) begin
                    res_q[0] <= core_result;
                    flg_q[0] <= core_flags;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        res_q[k] <= res_q[k-1];
                        flg_q[k] <= flg_q[k-1];
                    end
                end
            end
        end
    end

    assign inReady  = adv[0];
    assign outValid = vld[STAGES-1];
    assign result   = res_q[STAGES-1];
    assign carryout = flg_q[STAGES-1].carryout;
    assign zero     = flg_q[STAGES-1].zero;
    assign overflow = flg_q[STAGES-1].overflow;

`ifdef ALU_STICKY_OVF_EN
    // Set has priority over clear so an overflow is never missed.
    always_ff @(posedge clk) begin
        if (reset) begin
            stickyOverflow <= 1'b0;
        end else if (outValid && outReady && overflow) begin
            stickyOverflow <= 1'b1;
        end else if (clearSticky) begin
            stickyOverflow <= 1'b0;
        end
    end
`else
    // No sticky overflow state in this build.
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (32b/2 stages and 8b/1 stage).
// Expected bundles are queued on input transfer and checked on output.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic [2:0]  command = CMD_ADD;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] result;
    logic        carryout;
    logic        zero;
    logic        overflow;

    logic        d8_inValid = 1'b0;
    logic        d8_inReady;
    logic [7:0]  d8_a = '0;
    logic [7:0]  d8_b = '0;
    logic [2:0]  d8_cmd = CMD_ADD;
    logic        d8_outValid;
    logic        d8_outReady = 1'b1;
    logic [7:0]  d8_result;
    logic        d8_carry;
    logic        d8_zero;
    logic        d8_ovf;

`ifdef ALU_STICKY_OVF_EN
    logic clearSticky = 1'b0;
    logic stickyOverflow;
    logic d8_clear = 1'b0;
    logic d8_sticky;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int in_count = 0;
    int out_count = 0;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inReady(inReady),
        .operandA(operandA), .operandB(operandB), .command(command),
        .outValid(outValid), .outReady(outReady),
        .result(result), .carryout(carryout),
        .zero(zero), .overflow(overflow)
`ifdef ALU_STICKY_OVF_EN
        , .clearSticky(clearSticky), .stickyOverflow(stickyOverflow)
`endif
    );

    alu_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .reset(reset),
        .inValid(d8_inValid), .inReady(d8_inReady),
        .operandA(d8_a), .operandB(d8_b), .command(d8_cmd),
        .outValid(d8_outValid), .outReady(d8_outReady),
        .result(d8_result), .carryout(d8_carry),
        .zero(d8_zero), .overflow(d8_ovf)
`ifdef ALU_STICKY_OVF_EN
        , .clearSticky(d8_clear), .stickyOverflow(d8_sticky)
`endif
    );

    // Reference model: wide signed arithmetic, independent of adder tricks.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                   logic [2:0] cmd);
        exp_t   e;
        longint sa;
        longint sbv;
        longint d;
        logic [32:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.r = '0;
        e.c = 1'b0;
        e.o = 1'b0;
        case (cmd)
            CMD_ADD: begin
                e.r = a + b;
                u   = {1'b0, a} + {1'b0, b};
                e.c = u[32];
                d   = sa + sbv;
                e.o = (d != longint'($signed(e.r)));
            end
            CMD_SUB: begin
                e.r = a - b;
                e.c = (a >= b);
                d   = sa - sbv;
                e.o = (d != longint'($signed(e.r)));
            end
            CMD_SLT:  e.r = (sa < sbv) ? 32'd1 : 32'd0;
            CMD_XOR:  e.r = a ^ b;
            CMD_AND:  e.r = a & b;
            CMD_NAND: e.r = ~(a & b);
            CMD_NOR:  e.r = ~(a | b);
            default:  e.r = a | b;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    // Monitor: sample between edges; what is seen here transfers
    // at the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (outValid && outReady) begin
                out_count++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_output: got result=%h, none expected",
                             result);
                end else begin
                    e = sb.pop_front();
                    if ({result, carryout, zero, overflow}
                        !== {e.r, e.c, e.z, e.o}) begin
                        n_fails++;
                        $display("FAIL scoreboard: got r=%h c=%b z=%b o=%b, expected r=%h c=%b z=%b o=%b",
                                 result, carryout, zero, overflow,
                                 e.r, e.c, e.z, e.o);
                    end
                end
            end
            if (inValid && inReady) begin
                in_count++;
                sb.push_back(model(operandA, operandB, command));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [2:0] cmd, logic [31:0] a, logic [31:0] b);
        bit done;
        done = 1'b0;
        inValid  = 1'b1;
        command  = cmd;
        operandA = a;
        operandB = b;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = inReady;
            step();
        end
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: got inReady=0, expected 1 within 60 cycles");
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 60 && !empty; i++) begin
            step();
            empty = (sb.size() == 0) && !outValid;
        end
        n_checks++;
        if (!empty) begin
            n_fails++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        @(negedge clk);
        n_checks++;
        if (outValid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_outvalid: got %b expected 0", outValid);
        end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        n_checks++;
        if ({inReady, outValid} !== 2'b10) begin
            n_fails++;
            $display("FAIL reset_handshake: got inReady=%b outValid=%b expected 1 0",
                     inReady, outValid);
        end
        n_checks++;
        if ({result, carryout, zero, overflow} !== 35'd0) begin
            n_fails++;
            $display("FAIL reset_payload: got r=%h c=%b z=%b o=%b expected all 0",
                     result, carryout, zero, overflow);
        end
        n_checks++;
        if ({d8_inReady, d8_outValid, d8_result} !== 10'b10_0000_0000) begin
            n_fails++;
            $display("FAIL reset_w8: got inReady=%b outValid=%b r=%h expected 1 0 00",
                     d8_inReady, d8_outValid, d8_result);
        end
        step();
    endtask

    task automatic test_latency(logic [2:0] cmd, logic [31:0] a,
                                logic [31:0] b, string tag);
        int lat;
        send(cmd, a, b);
        inValid = 1'b0;
        lat = 0;
        while (lat < 20 && !outValid) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 2) begin
            n_fails++;
            $display("FAIL latency_%s: got %0d cycles expected 2", tag, lat);
        end
        drain();
    endtask

    task automatic test_add();
        test_latency(CMD_ADD, 32'd1, 32'd3, "add");
    endtask

    task automatic test_arith_edges();
        send(CMD_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        send(CMD_ADD, 32'hFFFF_FFFF, 32'd1);
        send(CMD_SUB, 32'd5, 32'd5);
        send(CMD_ADD, 32'h8000_0000, 32'h8000_0000);
        drain();
    endtask

    task automatic test_slt();
        send(CMD_SLT, 32'd5, -32'sd7);
        send(CMD_SLT, -32'sd7, 32'd5);
        send(CMD_SLT, 32'h8000_0000, 32'd1);
        send(CMD_SLT, 32'd1, 32'h8000_0000);
        drain();
    endtask

    task automatic test_logic();
        for (int c = 0; c < 8; c++) begin
            send(3'(c), 32'hF0F0_1234, 32'h0FF0_FFFF);
            send(3'(c), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            send(3'(c), $urandom, $urandom);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        n_checks++;
        if (cyc - t0 !== 8) begin
            n_fails++;
            $display("FAIL throughput: got %0d cycles for 8 bundles expected 8",
                     cyc - t0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int in0;
        int out0;
        in0  = in_count;
        out0 = out_count;
        outReady = 1'b0;
        send(CMD_ADD, 32'd0, 32'd0);
        send(CMD_ADD, 32'd1, 32'd1);
        inValid  = 1'b1;
        operandA = 32'd2;
        operandB = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({inReady, outValid, result} !== {2'b01, 32'd0}) begin
                n_fails++;
                $display("FAIL stall_%0d: got inReady=%b outValid=%b r=%h expected 0 1 0",
                         i, inReady, outValid, result);
            end
            step();
        end
        outReady = 1'b1;
        send(CMD_ADD, 32'd2, 32'd2);
        send(CMD_ADD, 32'd3, 32'd3);
        drain();
        n_checks++;
        if ({in_count - in0, out_count - out0} !== {32'd4, 32'd4}) begin
            n_fails++;
            $display("FAIL bp_counts: got in=%0d out=%0d expected 4 4",
                     in_count - in0, out_count - out0);
        end
    endtask

    task automatic test_random_ready();
        bit fin;
        fin = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(3'($urandom_range(0, 7)), $urandom, $urandom);
                end
                inValid = 1'b0;
                fin = 1'b1;
            end
            begin
                while (!fin) begin
                    outReady = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        drain();
    endtask

    task automatic test_reset_mid();
        outReady = 1'b0;
        send(CMD_ADD, 32'd10, 32'd10);
        send(CMD_ADD, 32'd20, 32'd20);
        inValid = 1'b0;
        reset   = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (outValid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid_outvalid: got %b expected 0", outValid);
        end
        step();
        reset    = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (outValid !== 1'b0) begin
                n_fails++;
                $display("FAIL stale_output_%0d: got outValid=%b r=%h expected 0",
                         i, outValid, result);
            end
            step();
        end
        test_latency(CMD_ADD, 32'd2, 32'd2, "after_reset");
    endtask

`ifdef ALU_STICKY_OVF_EN
    task automatic test_sticky();
        int k;
        clearSticky = 1'b1;
        step();
        clearSticky = 1'b0;
        send(CMD_ADD, 32'h7FFF_FFFF, 32'd1);
        drain();
        @(negedge clk);
        n_checks++;
        if (stickyOverflow !== 1'b1) begin
            n_fails++;
            $display("FAIL sticky_set: got %b expected 1", stickyOverflow);
        end
        send(CMD_ADD, 32'd1, 32'd1);
        send(CMD_XOR, 32'd1, 32'd3);
        send(CMD_SUB, 32'd9, 32'd4);
        drain();
        @(negedge clk);
        n_checks++;
        if (stickyOverflow !== 1'b1) begin
            n_fails++;
            $display("FAIL sticky_hold: got %b expected 1", stickyOverflow);
        end
        step();
        clearSticky = 1'b1;
        step();
        clearSticky = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stickyOverflow !== 1'b0) begin
            n_fails++;
            $display("FAIL sticky_clear: got %b expected 0", stickyOverflow);
        end
        step();
        outReady = 1'b0;
        send(CMD_SUB, 32'h8000_0000, 32'd1);
        inValid = 1'b0;
        k = 0;
        while (k < 20 && !outValid) begin
            step();
            k++;
        end
        clearSticky = 1'b1;
        outReady    = 1'b1;
        step();
        clearSticky = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stickyOverflow !== 1'b1) begin
            n_fails++;
            $display("FAIL sticky_set_wins: got %b expected 1", stickyOverflow);
        end
        drain();
    endtask
`endif

    task automatic test_w8();
        logic [7:0] ta [4];
        logic [7:0] tb_ [4];
        logic [2:0] tc [4];
        logic [10:0] tx [4];
        ta  = '{8'h7F, 8'hFF, 8'h80, 8'h05};
        tb_ = '{8'h01, 8'h01, 8'h01, 8'h05};
        tc  = '{CMD_ADD, CMD_ADD, CMD_SLT, CMD_SUB};
        // {result, carryout, zero, overflow}
        tx  = '{{8'h80, 3'b001}, {8'h00, 3'b110},
                {8'h01, 3'b000}, {8'h00, 3'b110}};
        for (int i = 0; i < 4; i++) begin
            d8_inValid = 1'b1;
            d8_a   = ta[i];
            d8_b   = tb_[i];
            d8_cmd = tc[i];
            @(negedge clk);
            n_checks++;
            if (d8_inReady !== 1'b1) begin
                n_fails++;
                $display("FAIL w8_ready_%0d: got %b expected 1", i, d8_inReady);
            end
            step();
            d8_inValid = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({d8_outValid, d8_result, d8_carry, d8_zero, d8_ovf}
                !== {1'b1, tx[i]}) begin
                n_fails++;
                $display("FAIL w8_case_%0d: got v=%b r=%h c=%b z=%b o=%b expected v=1 r=%h cz o=%b",
                         i, d8_outValid, d8_result, d8_carry, d8_zero, d8_ovf,
                         tx[i][10:3], tx[i][2:0]);
            end
            step();
        end
        @(negedge clk);
        n_checks++;
        if (d8_outValid !== 1'b0) begin
            n_fails++;
            $display("FAIL w8_idle: got outValid=%b expected 0", d8_outValid);
        end
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_arith_edges();
        test_slt();
        test_logic();
        test_back_to_back();
        test_backpressure();
        test_random_ready();
        test_reset_mid();
`ifdef ALU_STICKY_OVF_EN
        test_sticky();
`endif
        test_w8();
        n_checks++;
        if (in_count - out_count !== 2) begin
            n_fails++;
            $display("FAIL io_balance: got in-out=%0d expected 2 (discarded by reset)",
                     in_count - out_count);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
